// File: rtl/c2c_monitor_mc.sv
// Multi-channel C2C strobe counter: windowed per-channel counts,
// threshold classification, min/max tracking and sticky alarms.
module c2c_monitor_mc #(
  parameter int NumCh           = 4,
  parameter int CountW          = 8,
  parameter int WinW            = 10,
  parameter int ThreshLoDefault = 164,
  parameter int ThreshHiDefault = 200
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic                    i_start,
  input  logic                    i_continuous,
  input  logic [WinW-1:0]         i_win_len,
  input  logic [CountW-1:0]       i_thresh_lo,
  input  logic [CountW-1:0]       i_thresh_hi,
  input  logic [NumCh-1:0]        i_evt,
  input  logic                    i_clear,
  input  logic [NumCh-1:0]        i_irq_mask,
  output logic                    o_busy,
  output logic                    o_valid,
  output logic [NumCh*CountW-1:0] o_count,
  output logic [NumCh-1:0]        o_sat,
  output logic [NumCh-1:0]        o_slow,
  output logic [NumCh-1:0]        o_fast,
  output logic [NumCh-1:0]        o_slow_sticky,
  output logic [NumCh-1:0]        o_fast_sticky,
  output logic [NumCh*CountW-1:0] o_min,
  output logic [NumCh*CountW-1:0] o_max,
  output logic                    o_irq
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [WinW-1:0] WinOne = WinW'(1);

  state_t state, state_nx;

  logic [WinW-1:0]                   win_cnt;
  logic [WinW-1:0]                   win_tgt;
  logic                              last;
  logic                              upd;
  logic                              enter_run;
  logic [NumCh-1:0][CountW-1:0]      cnt, cnt_nx;
  logic [NumCh-1:0]                  sat_run, sat_nx;
  logic [NumCh-1:0]                  slow_nx, fast_nx;
  logic [NumCh-1:0][CountW-1:0]      min_nx, max_nx;
  logic [NumCh-1:0][CountW-1:0]      min_base, max_base;
  logic [NumCh-1:0][CountW-1:0]      count_r, min_r, max_r;
  logic [NumCh-1:0]                  ss_base, fs_base;

  assign win_tgt   = (i_win_len == '0) ? WinOne : i_win_len;
  assign last      = (win_cnt + WinOne) == win_tgt;
  assign upd       = (state == RUN) && i_enable && last;
  assign enter_run = (state_nx == RUN) && (state != RUN);

  assign o_busy  = (state != IDLE);
  assign o_valid = (state == DONE);
  assign o_count = count_r;
  assign o_min   = min_r;
  assign o_max   = max_r;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (i_start && i_enable) state_nx = RUN;
      RUN: begin
        if (!i_enable)  state_nx = IDLE;
        else if (last)  state_nx = DONE;
      end
      DONE: begin
        if (i_continuous && i_enable) state_nx = RUN;
        else                          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A clear landing on the final RUN edge is applied before the new result
  always_comb begin
    cnt_nx   = cnt;
    sat_nx   = sat_run;
    slow_nx  = '0;
    fast_nx  = '0;
    min_nx   = min_r;
    max_nx   = max_r;
    min_base = i_clear ? '1 : min_r;
    max_base = i_clear ? '0 : max_r;
    ss_base  = i_clear ? '0 : o_slow_sticky;
    fs_base  = i_clear ? '0 : o_fast_sticky;
    for (int c = 0; c < NumCh; c++) begin
      if (cnt[c] == '1) begin
        sat_nx[c] = sat_run[c] | i_evt[c];
      end else begin
        cnt_nx[c] = cnt[c] + CountW'(i_evt[c]);
      end
      slow_nx[c] = cnt_nx[c] < i_thresh_lo;
      fast_nx[c] = cnt_nx[c] > i_thresh_hi;
      min_nx[c]  = (cnt_nx[c] < min_base[c]) ? cnt_nx[c] : min_base[c];
      max_nx[c]  = (cnt_nx[c] > max_base[c]) ? cnt_nx[c] : max_base[c];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      win_cnt <= '0;
      cnt     <= '0;
      sat_run <= '0;
    end else begin
      state <= state_nx;
      if (enter_run) begin
        win_cnt <= '0;
        cnt     <= '0;
        sat_run <= '0;
      end else if (state == RUN) begin
        win_cnt <= win_cnt + WinOne;
        cnt     <= cnt_nx;
        sat_run <= sat_nx;
      end
    end
  end

  // In DONE the fresh result survives a clear: stickies/extremes restart from it
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_r       <= '0;
      o_sat         <= '0;
      o_slow        <= '0;
      o_fast        <= '0;
      o_slow_sticky <= '0;
      o_fast_sticky <= '0;
      min_r         <= '1;
      max_r         <= '0;
      o_irq         <= 1'b0;
    end else begin
      o_irq <= |((o_slow_sticky | o_fast_sticky) & i_irq_mask);
      if (upd) begin
        count_r       <= cnt_nx;
        o_sat         <= sat_nx;
        o_slow        <= slow_nx;
        o_fast        <= fast_nx;
        min_r         <= min_nx;
        max_r         <= max_nx;
        o_slow_sticky <= ss_base | slow_nx;
        o_fast_sticky <= fs_base | fast_nx;
      end else if (i_clear) begin
        if (state == DONE) begin
          o_slow_sticky <= o_slow;
          o_fast_sticky <= o_fast;
          min_r         <= count_r;
          max_r         <= count_r;
        end else begin
          o_slow_sticky <= '0;
          o_fast_sticky <= '0;
          min_r         <= '1;
          max_r         <= '0;
        end
      end
    end
  end

endmodule

// File: doc/c2c_monitor_mc.md
# c2c_monitor_mc

Multi-channel, parametrised successor to the single-channel C2C monitor: counts per-channel C2C delay-line/oscillator event strobes over a programmable reference-clock window and classifies each channel's count against low/high thresholds (defaults 164/200). It tracks per-channel min/max and raises sticky slow/fast alarms with a maskable interrupt. Sits in the chip-monitoring subsystem between the synchronised C2C sensor strobes and the CSR block.

## Interface
Parameters:
- NumCh, 4, number of monitored channels (1..16)
- CountW, 8, per-channel count width
- WinW, 10, window-length register width
- ThreshLoDefault, 164, reset value of low threshold
- ThreshHiDefault, 200, reset value of high threshold

Ports:
- i_clk  in  1  single clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_enable  in  1  block enable; low aborts any window
- i_start  in  1  one-cycle pulse, starts measurement from IDLE
- i_continuous  in  1  1: re-arm automatically after each window
- i_win_len  in  WinW  window length in clk cycles; 0 treated as 1
- i_thresh_lo / i_thresh_hi  in  CountW  thresholds, sampled at window end
- i_evt  in  NumCh  per-channel event strobes, one-cycle, already synchronised
- i_clear  in  1  clears sticky flags, min/max
- i_irq_mask  in  NumCh  1 = channel enabled for interrupt
- o_busy  out  1  state != IDLE
- o_valid  out  1  one-cycle pulse, results updated
- o_count  out  NumCh*CountW  last completed window counts, channel 0 in LSBs
- o_sat  out  NumCh  channel counter saturated in last window
- o_slow / o_fast  out  NumCh  last-window classification
- o_slow_sticky / o_fast_sticky  out  NumCh  sticky alarms
- o_min / o_max  out  NumCh*CountW  per-channel extremes since reset/clear
- o_irq  out  1  |((o_slow_sticky|o_fast_sticky) & i_irq_mask), registered

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN: i_start & i_enable. On entry: per-channel counters and window counter cleared.
- RUN: each cycle, channel counter += i_evt[c], saturating at 2^CountW-1 (sets sat bit). Window counter increments; after max(i_win_len,1) RUN cycles -> DONE.
- DONE (exactly one cycle): o_count, o_sat, o_slow, o_fast, o_min, o_max, sticky flags updated; o_valid = 1. Events in DONE are not counted.
- DONE -> RUN if i_continuous & i_enable, else IDLE. i_start ignored outside IDLE.
- Classification: slow = count < i_thresh_lo; fast = count > i_thresh_hi; count equal to a threshold is neither. If lo > hi both may assert; no check.
- min = min(min, count), max = max(max, count), unsigned.
- i_enable low in RUN: -> IDLE next cycle, no o_valid, outputs unchanged.
- i_clear: stickies -> 0, min -> all-ones, max -> 0. i_clear coincident with DONE: the new window's result wins (set/update over clear).
- Reset values: state IDLE; o_busy, o_valid, o_irq, o_count, o_sat, o_slow, o_fast, stickies, o_max = 0; o_min = all-ones. Thresholds default to ThreshLoDefault/ThreshHiDefault when ports tied to the defaults at integration.
- Reset asserted mid-window: window discarded, all state to reset values on the next edge.

## Timing
- i_start at cycle T -> o_busy = 1 at T+1; first counted event at T+1.
- Window N cycles: RUN cycles T+1..T+N, DONE at T+N+1 (o_valid high), outputs valid from T+N+1.
- Continuous mode period N+1 cycles; one dead cycle (DONE) per window.
- o_irq one cycle after sticky update (T+N+2).
- No combinational input-to-output paths.

## Test plan
- NumCh=4, win_len=200, ch0 strobe every cycle, ch1 every 2nd, ch2 none, ch3 every cycle -> o_count = {200,100,0,200}; o_slow = 4'b0110, o_fast = 0, o_valid at T+201.
- CountW=8, win_len=300, ch0 strobe every cycle -> o_count[0] = 255, o_sat[0] = 1, o_fast[0] = 1.
- Thresholds 164/200, counts exactly 164 and 200 -> slow = fast = 0; count 163 -> slow; 201 -> fast; sticky set, o_irq = 1 only if mask bit set.
- Continuous mode, 3 windows with counts 180, 170, 190 -> o_valid every win_len+1 cycles, o_min = 170, o_max = 190; i_clear then -> min all-ones, max 0, stickies 0.
- i_enable dropped mid-RUN, and separately i_rst mid-RUN -> IDLE next cycle, no o_valid, previous results held (enable) or all reset values (reset).
- win_len = 0 and i_start during RUN -> 1-cycle window; extra start ignored; i_clear coincident with DONE -> new result retained.
